// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the unified instruction/data block memory responder.
package mem_resp_pkg;
  localparam int BLOCK_W      = 128;
  localparam int BLOCK_ADDR_W = 28;
  localparam int CNT_W        = 4;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_e;
endpackage

// File: rtl/mem_block_array.sv
// Single-port block storage: one synchronous access per enable, read data held in a register.
module mem_block_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 256,
  parameter int AW           = $clog2(DEPTH_BLOCKS)
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [BLOCK_W-1:0] wdata_i,
  output logic [BLOCK_W-1:0] rdata_o
);
  logic [BLOCK_W-1:0] mem_q [DEPTH_BLOCKS];
  logic [BLOCK_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/unified_mem_responder.sv
// Serves icache and dcache block requests one at a time through a shared block array.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed dcache priority.
module unified_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int MEM_LATENCY  = 4,
  parameter int DEPTH_BLOCKS = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_mem_read,
  input  logic [BLOCK_ADDR_W-1:0] i_mem_address,
  output logic [BLOCK_W-1:0]      i_mem_readdata,
  output logic                    i_mem_busywait,
  input  logic                    d_mem_read,
  input  logic                    d_mem_write,
  input  logic [BLOCK_ADDR_W-1:0] d_mem_address,
  input  logic [BLOCK_W-1:0]      d_mem_writedata,
  output logic [BLOCK_W-1:0]      d_mem_readdata,
  output logic                    d_mem_busywait
);
  localparam int AW = $clog2(DEPTH_BLOCKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q;
  logic               wr_q;
  logic [BLOCK_W-1:0] wdata_q, i_rd_q, d_rd_q, arr_rdata;
  logic               d_req, d_pref, load_i, load_d, acc_done;

  assign d_req = d_mem_read | d_mem_write;

`ifdef MEM_ARB_RR_EN
  logic last_i_q;
  assign d_pref = last_i_q;
  always_ff @(posedge clk) begin
    if (reset)         last_i_q <= 1'b1;
    else if (acc_done) last_i_q <= (state_q == BUSY_I);
  end
`else
  assign d_pref = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_i   = 1'b0;
    load_d   = 1'b0;
    acc_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_req && (!i_mem_read || d_pref)) begin
          state_d = BUSY_D;
          load_d  = 1'b1;
        end else if (i_mem_read) begin
          state_d = BUSY_I;
          load_i  = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          acc_done = 1'b1;
          state_d  = (state_q == BUSY_I) ? RESP_I : RESP_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      i_rd_q  <= '0;
      d_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RESP_I)          i_rd_q <= arr_rdata;
      if (state_q == RESP_D && !wr_q) d_rd_q <= arr_rdata;
    end
  end

  // Request fields are captured at grant so a dropped request still completes.
  always_ff @(posedge clk) begin
    if (load_i) begin
      addr_q <= i_mem_address[AW-1:0];
      wr_q   <= 1'b0;
    end else if (load_d) begin
      addr_q  <= d_mem_address[AW-1:0];
      wr_q    <= d_mem_write;
      wdata_q <= d_mem_writedata;
    end
  end

  // Reset on the commit edge must not let a write land in the array.
  mem_block_array #(.DEPTH_BLOCKS(DEPTH_BLOCKS), .AW(AW)) u_array (
    .clk     (clk),
    .en_i    (acc_done && !reset),
    .we_i    (wr_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign i_mem_readdata = (state_q == RESP_I)          ? arr_rdata : i_rd_q;
  assign d_mem_readdata = (state_q == RESP_D && !wr_q) ? arr_rdata : d_rd_q;
  assign i_mem_busywait = i_mem_read && (state_q != RESP_I);
  assign d_mem_busywait = d_req && (state_q != RESP_D);
endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomized and directed check of unified_mem_responder against a transaction-level model.
module tb_unified_mem_responder;
  localparam int L     = 4;
  localparam int DEPTH = 256;

  logic         clk = 1'b0;
  logic         reset;
  logic         ireq, dr, dw;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] d_wdata;
  logic [127:0] i_mem_readdata, d_mem_readdata;
  logic         i_mem_busywait, d_mem_busywait;

  unified_mem_responder #(.MEM_LATENCY(L), .DEPTH_BLOCKS(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_mem_read(ireq), .i_mem_address(i_addr),
    .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
    .d_mem_read(dr), .d_mem_write(dw), .d_mem_address(d_addr),
    .d_mem_writedata(d_wdata), .d_mem_readdata(d_mem_readdata),
    .d_mem_busywait(d_mem_busywait)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: which port is being served, cycles of array time left,
  // and whether the one-cycle response slot is showing.
  logic [127:0] mm [DEPTH];
  bit           kn [DEPTH];
  bit           m_busy, m_resp, m_isd, m_wr, last_i;
  int           m_left, m_idx;
  logic [127:0] m_wd, ei, ed;
  bit           eiv, edv;

  initial begin
    m_busy = 0; m_resp = 0; last_i = 1; ei = '0; ed = '0; eiv = 0; edv = 0;
    for (int k = 0; k < DEPTH; k++) kn[k] = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_resp = 0; ei = '0; ed = '0; eiv = 1; edv = 1; last_i = 1;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_wr) begin
          mm[m_idx] = m_wd; kn[m_idx] = 1;
        end else if (m_isd) begin
          ed = mm[m_idx]; edv = kn[m_idx];
        end else begin
          ei = mm[m_idx]; eiv = kn[m_idx];
        end
        last_i = !m_isd;
        m_busy = 0; m_resp = 1;
      end
    end else if (ireq || dr || dw) begin
`ifdef MEM_ARB_RR_EN
      m_isd = (dr || dw) && (!ireq || last_i);
`else
      m_isd = (dr || dw);
`endif
      m_idx  = m_isd ? int'(d_addr % DEPTH) : int'(i_addr % DEPTH);
      m_wr   = m_isd && dw;
      m_wd   = d_wdata;
      m_left = L;
      m_busy = 1;
    end
  end

  bit run_cmp = 1;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("i_busywait", {127'd0, i_mem_busywait}, {127'd0, ireq && !(m_resp && !m_isd)});
      chk("d_busywait", {127'd0, d_mem_busywait}, {127'd0, (dr || dw) && !(m_resp && m_isd)});
      if (eiv) chk("i_readdata", i_mem_readdata, ei);
      if (edv) chk("d_readdata", d_mem_readdata, ed);
    end
  end

  // One request on one port; starts at posedge+1, counts busy cycles seen at negedge.
  task automatic req(input bit isd, input bit wr, input logic [27:0] a,
                     input logic [127:0] wd, output int busy);
    bit b;
    busy = 0;
    if (isd) begin dr = !wr; dw = wr; d_addr = a; d_wdata = wd; end
    else begin ireq = 1; i_addr = a; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      b = isd ? d_mem_busywait : i_mem_busywait;
      @(posedge clk); #1;
      if (!b) begin
        if (isd) begin dr = 0; dw = 0; end else ireq = 0;
        return;
      end
      busy++;
    end
    chk("req_timeout", 128'd1, 128'd0);
    ireq = 0; dr = 0; dw = 0;
  endtask

  logic [127:0] pre [64];
  int n, n2, ci, cd1, cd2, kk;
  bit bi, bd, idn, ddn, ph2;
  logic [127:0] wv;

  initial begin
    reset = 1; ireq = 0; dr = 0; dw = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_i_rd", i_mem_readdata, 128'd0);
    chk("rst_d_rd", d_mem_readdata, 128'd0);
    chk("rst_bw", {126'd0, i_mem_busywait, d_mem_busywait}, 128'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 64; k++) begin
      pre[k] = {$urandom, $urandom, $urandom, $urandom};
      req(1, 1, 28'(k), pre[k], n);
    end

    req(0, 0, 28'h0000010, '0, n);
    chk("icache_busy_cycles", 128'(n), 128'd5);
    chk("icache_block", i_mem_readdata, pre[16]);

    wv = 128'hDEADBEEF_00000000_00000000_00000001;
    req(1, 1, 28'h0000020, wv, n);
    req(1, 0, 28'h0000020, '0, n2);
    chk("wr_rd_busy_total", 128'(n + n2), 128'd10);
    chk("wr_rd_data", d_mem_readdata, wv);

    // Simultaneous requests; dcache re-requests right after its first service.
    ireq = 1; i_addr = 28'h0000005; dr = 1; d_addr = 28'h0000006;
    ci = 0; cd1 = 0; cd2 = 0; idn = 0; ddn = 0; ph2 = 0; kk = 0;
    while (!(idn && ddn) && kk < 200) begin
      @(negedge clk); #1;
      bi = i_mem_busywait; bd = d_mem_busywait;
      if (!idn && bi) ci++;
      if (!ddn && bd) begin if (ph2) cd2++; else cd1++; end
      @(posedge clk); #1;
      if (!idn && !bi) begin idn = 1; ireq = 0; end
      if (!ddn && !bd) begin
        if (!ph2) begin ph2 = 1; d_addr = 28'h0000007; end
        else begin ddn = 1; dr = 0; end
      end
      kk++;
    end
    chk("tie_done", {127'd0, idn && ddn}, 128'd1);
    chk("tie_d_first", 128'(cd1), 128'd5);
`ifdef MEM_ARB_RR_EN
    chk("tie_i_busy", 128'(ci), 128'd11);
    chk("tie_d_second", 128'(cd2), 128'd11);
`else
    chk("tie_i_busy", 128'(ci), 128'd17);
    chk("tie_d_second", 128'(cd2), 128'd5);
`endif
    chk("tie_i_data", i_mem_readdata, pre[5]);
    chk("tie_d_data", d_mem_readdata, pre[7]);

    wv = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    req(1, 1, 28'h0000100, wv, n);
    req(1, 0, 28'h0000000, '0, n);
    chk("wrap_data", d_mem_readdata, wv);

    // Reset while a write sits at count 2.
    dw = 1; d_addr = 28'h0000030; d_wdata = ~pre[48];
    repeat (3) @(posedge clk);
    #1 reset = 1; dw = 0;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("midrst_d_rd", d_mem_readdata, 128'd0);
    chk("midrst_i_rd", i_mem_readdata, 128'd0);
    @(posedge clk); #1;
    req(1, 0, 28'h0000030, '0, n);
    chk("midrst_old_data", d_mem_readdata, pre[48]);

    // dcache read dropped mid-access still completes.
    dr = 1; d_addr = 28'h0000011;
    repeat (2) @(posedge clk);
    #1 dr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drop_d_data", d_mem_readdata, pre[17]);
    @(posedge clk); #1;
    req(0, 0, 28'h0000012, '0, n);
    chk("drop_next_i_busy", 128'(n), 128'd5);
    chk("drop_next_i_data", i_mem_readdata, pre[18]);

    // Randomized traffic from both caches with occasional resets and drops.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      bi = i_mem_busywait; bd = d_mem_busywait;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 249) == 0);
      if (ireq && (!bi || $urandom_range(0, 99) == 0)) ireq = 0;
      else if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1; i_addr = {20'($urandom), 8'($urandom_range(0, 63))};
      end
      if ((dr || dw) && (!bd || $urandom_range(0, 99) == 0)) begin dr = 0; dw = 0; end
      else if (!(dr || dw) && $urandom_range(0, 2) == 0) begin
        dr = 1'($urandom); dw = 1'($urandom); if (!dr && !dw) dw = 1;
        d_addr = {20'($urandom), 8'($urandom_range(0, 63))};
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    ireq = 0; dr = 0; dw = 0; reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, giving array-access cycles per block transfer (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_BLOCKS, default 256, giving the number of 128-bit blocks stored (power of two).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_mem_read, input, 1, icache block-read request, held until it samples busywait low.
REQ-006 SHALL have port i_mem_address, input, 28, icache block address.
REQ-007 SHALL have port i_mem_readdata, output, 128, block returned to icache.
REQ-008 SHALL have port i_mem_busywait, output, 1, icache stall.
REQ-009 SHALL have ports d_mem_read and d_mem_write, input, 1 each, dcache block requests, held until busywait is sampled low.
REQ-010 SHALL have port d_mem_address, input, 28, dcache block address.
REQ-011 SHALL have port d_mem_writedata, input, 128, write-back block.
REQ-012 SHALL have port d_mem_readdata, output, 128, block returned to dcache.
REQ-013 SHALL have port d_mem_busywait, output, 1, dcache stall.

Function
REQ-014 SHALL implement FSM IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D; one request is served at a time.
REQ-015 In IDLE with a pending request, the next edge SHALL enter BUSY_x for the granted port and load a 4-bit cycle counter with 0.
REQ-016 In BUSY_x the counter SHALL increment each cycle; at the edge where it equals MEM_LATENCY-1, a read latches the addressed block into x_mem_readdata or a write commits d_mem_writedata; the FSM then enters RESP_x.
REQ-017 RESP_x SHALL last exactly one cycle, then return to IDLE.
REQ-018 x_mem_busywait SHALL be combinational: equal to the port's request OR, except low while in RESP_x.
REQ-019 A request therefore sees busywait high for exactly MEM_LATENCY+1 cycles (4 -> 5 cycles); readdata is valid in RESP_x and held until that port's next read completes.
REQ-020 The array index SHALL be address modulo DEPTH_BLOCKS (upper bits ignored, wrap-around).
REQ-021 If d_mem_read and d_mem_write are both high, the access SHALL be treated as a write.
REQ-022 A request deasserted while in BUSY_x SHALL NOT abort the access; the transfer completes and RESP_x occurs.
REQ-023 A request arriving for the non-granted port SHALL stay pending (busywait high) and be served from the following IDLE cycle.
REQ-024 With both ports requesting in IDLE, the dcache SHALL be granted (default arbitration).

Reset
REQ-025 Reset SHALL force IDLE, counter 0, both readdata outputs 0x0, and the round-robin pointer to "icache last served".
REQ-026 Reset mid-access SHALL abandon the transfer without committing a write; the array contents SHALL NOT be cleared.
REQ-027 During and after reset, busywait SHALL follow REQ-018 (high if request held).

Configuration
REQ-028 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the port not served last, and the pointer updates on entering RESP_x.
REQ-029 Without MEM_ARB_RR_EN, fixed dcache priority SHALL apply (REQ-024) and no pointer register SHALL exist.

Structure
REQ-030 Package mem_resp_pkg SHALL hold the state enum, BLOCK_W=128, BLOCK_ADDR_W=28, and CNT_W=4.
REQ-031 Storage SHALL be a sub-module mem_block_array: one synchronous port with write enable, write data and read data latched on enable.

Verification
REQ-032 icache read of address 0x0000010 (MEM_LATENCY=4) -> i_mem_busywait high for 5 cycles, then i_mem_readdata equals the preloaded block.
REQ-033 dcache write of 0xDEADBEEF_..._0001 to 0x0000020, then dcache read of 0x0000020 -> the same 128-bit value is returned; total 10 busy cycles.
REQ-034 i and d requests raised in the same IDLE cycle -> dcache served first; without MEM_ARB_RR_EN the icache is served after it; with the macro, the second tie goes to icache.
REQ-035 dcache write to 0x0000100 with DEPTH_BLOCKS=256 -> read of 0x0000000 returns the written block (wrap).
REQ-036 Reset asserted in BUSY_D of a write at count 2 -> IDLE next cycle, readdata 0, later read shows old contents.
REQ-037 d_mem_read dropped in BUSY_D -> RESP_D still occurs one cycle after count reaches 3; next icache request is accepted from IDLE.
